// File: rtl/ppu_video_source_if.sv
// rtl/ppu_video_source_if.sv - NES dot-stream bundle: dot strobe, counters, palette index and frame strobes
interface ppu_video_source_if;
  logic       ce_dot;
  logic [8:0] count_h;
  logic [8:0] count_v;
  logic [5:0] color;
  logic       frame_start;
  logic       vblank_start;
  logic       odd_frame;

  modport master (
    output ce_dot, count_h, count_v, color, frame_start, vblank_start, odd_frame
  );

  modport slave (
    input ce_dot, count_h, count_v, color, frame_start, vblank_start, odd_frame
  );
endinterface

// File: rtl/ppu_video_source.sv
// rtl/ppu_video_source.sv - free-running NES dot-timing source with test patterns
// Optional PPU_SRC_ODD_SKIP_EN: odd rendered frames drop the last pre-render dot.
module ppu_video_source #(
  parameter int CE_DIV  = 4,
  parameter int H_DOTS  = 341,
  parameter int V_LINES = 262
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic                      i_rendering,
  input  logic [1:0]                i_pattern,
  input  logic [5:0]                i_solid_color,
  ppu_video_source_if.master        o_vid
);

  localparam int DIV_W = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam logic [8:0] LAST_H   = 9'(H_DOTS - 1);
  localparam logic [8:0] LAST_IDX = 9'(V_LINES - 1);

  logic [DIV_W-1:0] r_div;
  logic             r_ce;
  logic [8:0]       r_h;
  logic [8:0]       r_idx;
  logic [8:0]       r_v;
  logic [5:0]       r_color;
  logic             r_frame_start;
  logic             r_vblank_start;
  logic             r_odd;

  logic             w_wrap;
  logic             w_step;
  logic             w_skip;
  logic             w_line_end;
  logic             w_frame_wrap;
  logic [8:0]       w_next_h;
  logic [8:0]       w_next_idx;
  logic [8:0]       w_next_v;
  logic             w_visible;
  logic [5:0]       w_bar;
  logic [5:0]       w_hbar;
  logic [5:0]       w_color;

  always_comb begin
    w_wrap = (r_div == DIV_W'(CE_DIV - 1));
    w_step = w_wrap & i_enable;
`ifdef PPU_SRC_ODD_SKIP_EN
    w_skip = r_odd & i_rendering & (r_idx == LAST_IDX) & (r_h == 9'(H_DOTS - 2));
`else
    w_skip = 1'b0;
`endif
    w_line_end   = (r_h == LAST_H) | w_skip;
    w_frame_wrap = w_line_end & (r_idx == LAST_IDX);
    w_next_h     = w_line_end ? 9'd0 : r_h + 9'd1;
    w_next_idx   = r_idx;
    if (w_line_end) begin
      w_next_idx = (r_idx == LAST_IDX) ? 9'd0 : r_idx + 9'd1;
    end
    // Pre-render line is reported as 511, as the PPU does.
    w_next_v = (w_next_idx == LAST_IDX) ? 9'd511 : w_next_idx;
  end

  // Colour is derived from the counters the dot is about to show, so it lands with them.
  always_comb begin
    w_visible = i_rendering & (w_next_h < 9'd256) & (w_next_v < 9'd240);
    w_bar     = {2'b00, w_next_h[7:5], 1'b0} + 6'h10;
    w_hbar    = {w_next_v[7:6], w_next_v[5:2]};
    if (w_hbar == 6'h0D || w_hbar == 6'h0E) begin
      w_hbar = 6'h0F;
    end
    w_color = 6'h0F;
    if (w_visible) begin
      case (i_pattern)
        2'd0:    w_color = w_bar;
        2'd1:    w_color = w_hbar;
        2'd2:    w_color = (w_next_h[3] ^ w_next_v[3]) ? 6'h30 : 6'h0F;
        default: w_color = i_solid_color;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_div          <= '0;
      r_ce           <= 1'b0;
      r_h            <= 9'd0;
      r_idx          <= 9'd0;
      r_v            <= 9'd0;
      r_color        <= 6'h0F;
      r_frame_start  <= 1'b0;
      r_vblank_start <= 1'b0;
      r_odd          <= 1'b0;
    end else begin
      r_div          <= w_wrap ? '0 : r_div + 1'b1;
      r_ce           <= w_wrap;
      r_frame_start  <= w_step & w_frame_wrap;
      r_vblank_start <= w_step & (w_next_idx == 9'd241) & (w_next_h == 9'd1);
      if (w_step) begin
        r_h     <= w_next_h;
        r_idx   <= w_next_idx;
        r_v     <= w_next_v;
        r_color <= w_color;
        if (w_frame_wrap) begin
          r_odd <= ~r_odd;
        end
      end
    end
  end

  assign o_vid.ce_dot       = r_ce;
  assign o_vid.count_h      = r_h;
  assign o_vid.count_v      = r_v;
  assign o_vid.color        = r_color;
  assign o_vid.frame_start  = r_frame_start;
  assign o_vid.vblank_start = r_vblank_start;
  assign o_vid.odd_frame    = r_odd;

endmodule

// File: tb/tb_ppu_video_source.sv
// tb/tb_ppu_video_source.sv - bench for ppu_video_source (full-size and short-line instances)
module tb_ppu_video_source;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       rend = 1'b0;
  logic [1:0] pat = 2'd0;
  logic [5:0] solid = 6'd0;

  int n_tests = 0;
  int n_fail  = 0;

  ppu_video_source_if vif_a ();
  ppu_video_source_if vif_b ();

  ppu_video_source #(.CE_DIV(4), .H_DOTS(341), .V_LINES(262)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_rendering(rend),
    .i_pattern(pat), .i_solid_color(solid), .o_vid(vif_a)
  );

  ppu_video_source #(.CE_DIV(2), .H_DOTS(10), .V_LINES(262)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_rendering(rend),
    .i_pattern(pat), .i_solid_color(solid), .o_vid(vif_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int p_div(input int k);
    return (k == 0) ? 4 : 2;
  endfunction

  function automatic int p_h(input int k);
    return (k == 0) ? 341 : 10;
  endfunction

  localparam int P_V = 262;

  // Reference model: position is the dot index within the frame.
  int         m_clk [2];
  int         m_pos [2];
  logic       m_odd [2];
  logic       m_ce  [2];
  logic       m_fs  [2];
  logic       m_vb  [2];
  logic [5:0] m_col [2];
  bit         chk_on = 0;

  function automatic logic [5:0] model_color(input int h, input int v, input logic r,
                                             input logic [1:0] p, input logic [5:0] s);
    int c;
    if (!r || h >= 256 || v >= 240) return 6'h0F;
    case (p)
      2'd0: c = 16 + 2 * (h / 32);
      2'd1: begin
        c = v / 4;
        if (c == 13 || c == 14) c = 15;
      end
      2'd2: c = (((h / 8) % 2) != ((v / 8) % 2)) ? 48 : 15;
      default: c = int'(s);
    endcase
    return c[5:0];
  endfunction

  function automatic int line_to_v(input int line);
    return (line == P_V - 1) ? 511 : line;
  endfunction

  task automatic model_step(input int k);
    int npos;
    int flen;
    if (rst) begin
      m_clk[k] = 0; m_pos[k] = 0; m_odd[k] = 0; m_ce[k] = 0;
      m_fs[k] = 0; m_vb[k] = 0; m_col[k] = 6'h0F;
      chk_on = 1;
    end else begin
      m_clk[k]++;
      m_ce[k] = ((m_clk[k] % p_div(k)) == 0);
      m_fs[k] = 0;
      m_vb[k] = 0;
      if (m_ce[k] && en) begin
        flen = p_h(k) * P_V;
        npos = (m_pos[k] + 1) % flen;
`ifdef PPU_SRC_ODD_SKIP_EN
        if (m_odd[k] && rend && m_pos[k] == flen - 2) npos = 0;
`endif
        m_pos[k] = npos;
        m_fs[k]  = (npos == 0);
        if (m_fs[k]) m_odd[k] = ~m_odd[k];
        m_vb[k]  = (npos == 241 * p_h(k) + 1);
        m_col[k] = model_color(npos % p_h(k), line_to_v(npos / p_h(k)), rend, pat, solid);
      end
    end
  endtask

  function automatic logic [27:0] model_vec(input int k);
    return {m_ce[k], 9'(m_pos[k] % p_h(k)), 9'(line_to_v(m_pos[k] / p_h(k))),
            m_col[k], m_fs[k], m_vb[k], m_odd[k]};
  endfunction

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("stream_a", {vif_a.ce_dot, vif_a.count_h, vif_a.count_v, vif_a.color,
                         vif_a.frame_start, vif_a.vblank_start, vif_a.odd_frame}, model_vec(0));
      check("stream_b", {vif_b.ce_dot, vif_b.count_h, vif_b.count_v, vif_b.color,
                         vif_b.frame_start, vif_b.vblank_start, vif_b.odd_frame}, model_vec(1));
    end
  end

  task automatic wait_a(input int h, input int v, input int limit, output bit ok);
    ok = 0;
    for (int g = 0; g < limit && !ok; g++) begin
      @(negedge clk);
      if (vif_a.count_h == h && (v < 0 || vif_a.count_v == v)) ok = 1;
    end
  endtask

  function automatic int vnext(input int p);
    return (p == 260) ? 511 : ((p == 511) ? 0 : p + 1);
  endfunction

  task automatic frame_measure(input logic r_in, input string tag);
    bit   got;
    int   dots, trans, badv, nvb, bad240, exp_len, pv;
    rend = r_in; pat = 2'd0; en = 1'b1;
    got = 0;
    for (int g = 0; g < 6000 && !got; g++) begin
      @(negedge clk);
      if (vif_b.frame_start) got = 1;
    end
    check({tag, "_sync"}, 32'(got), 32'd1);
    if (!got) return;
    exp_len = 2620;
`ifdef PPU_SRC_ODD_SKIP_EN
    if (m_odd[1] && r_in) exp_len = 2619;
`endif
    dots = 0; trans = 0; badv = 0; nvb = 0; bad240 = 0; pv = 0; got = 0;
    for (int g = 0; g < 6000 && !got; g++) begin
      @(negedge clk);
      if (vif_b.ce_dot) dots++;
      if (int'(vif_b.count_v) != pv) begin
        trans++;
        if (int'(vif_b.count_v) != vnext(pv)) badv++;
        pv = int'(vif_b.count_v);
      end
      if (vif_b.vblank_start) begin
        nvb++;
        if (vif_b.count_h != 9'd1 || vif_b.count_v != 9'd241) badv++;
      end
      if (vif_b.ce_dot && vif_b.count_v == 9'd240 && vif_b.color != 6'h0F) bad240++;
      if (vif_b.frame_start) got = 1;
    end
    check({tag, "_end"}, 32'(got), 32'd1);
    check({tag, "_dots"}, 32'(dots), 32'(exp_len));
    check({tag, "_lines"}, 32'(trans), 32'd262);
    check({tag, "_vseq"}, 32'(badv), 32'd0);
    check({tag, "_vblanks"}, 32'(nvb), 32'd1);
    check({tag, "_line240"}, 32'(bad240), 32'd0);
    check({tag, "_fs_pos"}, {vif_b.count_h, vif_b.count_v}, 32'd0);
    @(negedge clk);
    check({tag, "_fs_single"}, 32'(vif_b.frame_start), 32'd0);
  endtask

  typedef struct {
    logic [1:0] pat;
    logic       rend;
    logic [5:0] solid;
    int         h;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl [11];
  localparam logic [27:0] RST_VEC = {1'b0, 9'd0, 9'd0, 6'h0F, 3'b000};

  initial begin
    bit ok;
    int n, nce, bad;

    tbl[0]  = '{2'd3, 1'b1, 6'h2A,   5, 6'h2A};
    tbl[1]  = '{2'd2, 1'b1, 6'h00,   8, 6'h30};
    tbl[2]  = '{2'd0, 1'b0, 6'h00,  10, 6'h0F};
    tbl[3]  = '{2'd2, 1'b1, 6'h00,  16, 6'h0F};
    tbl[4]  = '{2'd0, 1'b1, 6'h00,  31, 6'h10};
    tbl[5]  = '{2'd0, 1'b1, 6'h00,  32, 6'h12};
    tbl[6]  = '{2'd1, 1'b1, 6'h00, 100, 6'h00};
    tbl[7]  = '{2'd0, 1'b1, 6'h00, 224, 6'h1E};
    tbl[8]  = '{2'd0, 1'b1, 6'h00, 255, 6'h1E};
    tbl[9]  = '{2'd0, 1'b1, 6'h00, 256, 6'h0F};
    tbl[10] = '{2'd0, 1'b1, 6'h00, 340, 6'h0F};

    // Reset for three clocks, then time the first dot strobes.
    repeat (3) @(posedge clk);
    #1;
    check("reset_a", {vif_a.ce_dot, vif_a.count_h, vif_a.count_v, vif_a.color,
                      vif_a.frame_start, vif_a.vblank_start, vif_a.odd_frame}, RST_VEC);
    @(negedge clk);
    rst = 1'b0;
    n = 0; ok = 0; nce = 0;
    for (int g = 0; g < 20 && !ok; g++) begin
      @(posedge clk); #1;
      n++;
      if (vif_b.ce_dot && nce == 0) nce = n;
      if (vif_a.ce_dot) ok = 1;
    end
    check("first_ce_a_clk", 32'(n), 32'd4);
    check("first_ce_b_clk", 32'(nce), 32'd2);
    check("first_dot_h", 32'(vif_a.count_h), 32'd1);
    check("first_dot_color", 32'(vif_a.color), 32'h0F);
    n = 0; ok = 0;
    for (int g = 0; g < 20 && !ok; g++) begin
      @(posedge clk); #1;
      n++;
      if (vif_a.ce_dot) ok = 1;
    end
    check("second_ce_gap", 32'(n), 32'd4);

    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      pat = tbl[i].pat; rend = tbl[i].rend; solid = tbl[i].solid;
      wait_a(tbl[i].h, 0, 1500, ok);
      check("tbl_reach", 32'(ok), 32'd1);
      check($sformatf("tbl_color_h%0d", tbl[i].h), 32'(vif_a.color), 32'(tbl[i].exp));
    end

    // Freeze the counters for 20 dots mid-line.
    wait_a(100, 1, 3000, ok);
    check("frz_reach", 32'(ok), 32'd1);
    en = 1'b0;
    nce = 0; bad = 0;
    for (int g = 0; g < 80; g++) begin
      @(negedge clk);
      if (vif_a.ce_dot) nce++;
      if (vif_a.count_h != 9'd100 || vif_a.count_v != 9'd1 || vif_a.color != 6'h16 ||
          vif_a.frame_start || vif_a.vblank_start) bad++;
    end
    check("frz_pulses", 32'(nce), 32'd20);
    check("frz_hold", 32'(bad), 32'd0);
    en = 1'b1;
    ok = 0;
    for (int g = 0; g < 8 && !ok; g++) begin
      @(negedge clk);
      if (vif_a.ce_dot) ok = 1;
    end
    check("frz_resume_ce", 32'(ok), 32'd1);
    check("frz_resume_pos", {vif_a.count_h, vif_a.count_v}, {9'd101, 9'd1});
    check("frz_resume_color", 32'(vif_a.color), 32'h16);

    frame_measure(1'b1, "frame_r1a");
    frame_measure(1'b1, "frame_r1b");
    frame_measure(1'b0, "frame_r0");

    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      en = ($urandom_range(7) != 0);
      if ($urandom_range(31) == 0) begin
        pat   = 2'($urandom_range(3));
        rend  = 1'($urandom_range(1));
        solid = 6'($urandom_range(63));
      end
    end

    // Reset in the middle of a line.
    en = 1'b1;
    wait_a(200, -1, 3000, ok);
    check("mid_reset_reach", 32'(ok), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_reset_a", {vif_a.ce_dot, vif_a.count_h, vif_a.count_v, vif_a.color,
                          vif_a.frame_start, vif_a.vblank_start, vif_a.odd_frame}, RST_VEC);
    check("mid_reset_b", {vif_b.ce_dot, vif_b.count_h, vif_b.count_v, vif_b.color,
                          vif_b.frame_start, vif_b.vblank_start, vif_b.odd_frame}, RST_VEC);
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ppu_video_source.md
Name: ppu_video_source

Overview:
- Transmitter end of the NES dot-stream interface: produces 6-bit palette index `color` plus `count_h`/`count_v` with exact NES PPU timing.
- Stands in for the PPU when driving the video output stage: bring-up, test patterns, and free-running sync when the core is halted.
- Also provides the dot clock-enable, frame-start and vblank-start strobes.

Parameters:
- CE_DIV, 4, master clocks per dot; must be 2..16.
- H_DOTS, 341, dots per line (count_h 0..H_DOTS-1).
- V_LINES, 262, lines per frame, including the pre-render line.

Ports:
- clk  in  1  master clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  0 = counters frozen (outputs hold); ce_dot still toggles.
- rendering  in  1  rendering-enabled flag; gates odd-frame skip and pattern output.
- pattern  in  2  0 = vertical bars, 1 = horizontal bars, 2 = checker, 3 = solid `solid_color`.
- solid_color  in  6  colour used by pattern 3.
- ce_dot  out  1  one-clk pulse per dot.
- count_h  out  9  dot counter.
- count_v  out  9  line counter; pre-render line = 511.
- color  out  6  palette index for the current dot.
- frame_start  out  1  one-clk pulse coincident with the ce_dot on which count_v goes 511->0 and count_h = 0.
- vblank_start  out  1  one-clk pulse coincident with the ce_dot at count_v = 241, count_h = 1.
- odd_frame  out  1  frame parity, toggled at each frame_start.

Behaviour:
- **Interface:** one clock (clk); reset is synchronous and active-high.
- **Reset values:**
  - ce_dot = 0, count_h = 0, count_v = 0, color = 0x0F (black).
  - frame_start = 0, vblank_start = 0, odd_frame = 0.
  - Divider = 0; first ce_dot on the CE_DIV-th clk after reset deassert.
  - Reset mid-line overrides everything on the same edge.
- **Divider:**
  - Counts 0..CE_DIV-1; ce_dot registered high when the divider wraps.
  - Exactly 1 pulse per CE_DIV clks, even when enable = 0.
- **Counter advance** (only on a ce_dot clk with enable = 1):
  - count_h += 1; at H_DOTS-1 wraps to 0 and advances line.
  - Line sequence: 0..V_LINES-2, then 511 (pre-render), then 0.
  - Raw line index is kept internally; count_v = (idx == V_LINES-1) ? 511 : idx.
- **Output timing:**
  - count_h, count_v, color, frame_start and vblank_start all update on the same clk edge as ce_dot is asserted.
  - Zero extra latency between counts and color.
  - The consumer samples them on its pix_ce.
- **Colour generation** (registered, computed from the next-state counters):
  - Outside the visible window (count_h >= 256 or count_v >= 240, including 511), or when rendering = 0: 0x0F.
  - Pattern 0: {2'b00, next_h[7:5], 1'b0} + 0x10, i.e. 8 bars 0x10,0x12..0x1E.
  - Pattern 1: {next_v[7:6], next_v[5:2]}, capped so 0x0D/0x0E/0x0F map to 0x0F.
  - Pattern 2: (next_h[3] ^ next_v[3]) ? 0x30 : 0x0F.
  - Pattern 3: solid_color.
  - A pattern change takes effect on the next dot; no mid-dot glitch.
- **Strobes:**
  - frame_start is asserted on the dot where count_v becomes 0 from 511 (count_h = 0).
  - vblank_start fires once per frame.
  - While enable = 0, neither strobe fires.
- **Boundaries:**
  - enable dropping mid-line freezes the counts at the current dot; resuming continues from the next dot.
  - No counter value outside the sets above is ever emitted.

Optional Feature:
- Macro: `PPU_SRC_ODD_SKIP_EN`.
- Defined: when odd_frame = 1 and rendering = 1, the pre-render line (511) steps from count_h 339 directly to count_h 0 / count_v 0. That frame is one dot shorter (89341 dots vs 89342).
- Undefined: every frame is exactly H_DOTS*V_LINES dots; odd_frame still toggles.

Test Plan:
- **Reset and first dot:** reset 3 clks with CE_DIV = 4, then release → ce_dot first at clk 4 and every 4 clks after; count_h steps 0->1 on the first pulse; color = 0x0F.
- **Frame wrap:** run 1 frame with pattern 0 and rendering = 1 → count_v sequence is 0..260, 511, 0; frame_start is a single pulse at 511->0; vblank_start at (241,1); 89342 ce_dot pulses per frame (macro off).
- **Bars pattern:** pattern 0 → color 0x10 at count_h 0..31, 0x12 at 32..63, 0x1E at 224..255, and 0x0F at 256..340 and on line 240.
- **Enable freeze:** enable = 0 at (100,50) for 20 dots → count and color hold; ce_dot keeps pulsing; no strobes; resuming gives (101,50).
- **Odd-frame skip** (`PPU_SRC_ODD_SKIP_EN` defined, rendering = 1): odd frame goes (339,511)->(0,0) with 89341 dots; even frame has 89342; with rendering = 0 every frame has 89342.
- **Mid-line reset:** assert reset at (200,120) → next clk all outputs at reset values; no frame_start pulse.
